// File: rtl/video_timing_gen_if.sv
// Raster timing bundle: run request in, sync/enable/coordinate/strobe outputs back.
// The generator connects through the master modport and the consumer through the slave modport.
interface video_timing_gen_if #(
  parameter int CNT_WIDTH = 12
);
  logic                 iEN;
  logic                 oHS;
  logic                 oVS;
  logic                 oDE;
  logic [CNT_WIDTH-1:0] oX;
  logic [CNT_WIDTH-1:0] oY;
  logic                 oFRAME_START;
  logic                 oLINE_START;
  logic                 oBUSY;
  logic [15:0]          oFRAME_CNT;

  modport master (
    input  iEN,
    output oHS, oVS, oDE, oX, oY, oFRAME_START, oLINE_START, oBUSY, oFRAME_CNT
  );

  modport slave (
    output iEN,
    input  oHS, oVS, oDE, oX, oY, oFRAME_START, oLINE_START, oBUSY, oFRAME_CNT
  );
endinterface

// File: rtl/video_timing_gen.sv
// Frame-aligned raster timing generator: h/v counters, registered HS/VS/DE, coordinates and strobes.
// Optional frame counter is built only when VIDEO_TIMING_FRAME_CNT_EN is defined.
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int CNT_WIDTH = 12
) (
  input  logic               CLK,
  input  logic               RST_N,
  video_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_WIDTH-1:0] C_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] C_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] H_LAST   = CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] V_LAST   = CNT_WIDTH'(V_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] H_ACT    = CNT_WIDTH'(H_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] V_ACT    = CNT_WIDTH'(V_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] HS_BEG   = CNT_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [CNT_WIDTH-1:0] HS_END   = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_WIDTH-1:0] VS_BEG   = CNT_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [CNT_WIDTH-1:0] VS_END   = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic                 HS_ON    = (HS_POL != 0);
  localparam logic                 VS_ON    = (VS_POL != 0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_hcnt;
  logic [CNT_WIDTH-1:0] r_vcnt;
  logic [CNT_WIDTH-1:0] w_hcnt_nxt;
  logic [CNT_WIDTH-1:0] w_vcnt_nxt;

  logic                 w_run;
  logic                 w_de;
  logic                 w_hs_act;
  logic                 w_vs_act;
  logic                 w_fs;
  logic                 w_ls;

  logic                 r_hs;
  logic                 r_vs;
  logic                 r_de;
  logic [CNT_WIDTH-1:0] r_x;
  logic [CNT_WIDTH-1:0] r_y;
  logic                 r_fs;
  logic                 r_ls;
  logic                 r_busy;

  // State and raster counter registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_hcnt  <= C_ZERO;
      r_vcnt  <= C_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_vcnt  <= w_vcnt_nxt;
    end
  end

  // Next state and counter advance; iEN is only honoured at the final pixel of a frame
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_vcnt_nxt  = r_vcnt;
    case (r_state)
      ST_IDLE: begin
        w_hcnt_nxt = C_ZERO;
        w_vcnt_nxt = C_ZERO;
        if (vid.iEN) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_hcnt == H_LAST) begin
          w_hcnt_nxt = C_ZERO;
          if (r_vcnt == V_LAST) begin
            w_vcnt_nxt  = C_ZERO;
            w_state_nxt = vid.iEN ? ST_RUN : ST_IDLE;
          end else begin
            w_vcnt_nxt = r_vcnt + C_ONE;
          end
        end else begin
          w_hcnt_nxt = r_hcnt + C_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_hcnt_nxt  = C_ZERO;
        w_vcnt_nxt  = C_ZERO;
      end
    endcase
  end

  assign w_run    = (r_state == ST_RUN);
  assign w_de     = w_run && (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_hs_act = w_run && (r_hcnt >= HS_BEG) && (r_hcnt < HS_END);
  assign w_vs_act = w_run && (r_vcnt >= VS_BEG) && (r_vcnt < VS_END);
  assign w_fs     = w_run && (r_hcnt == C_ZERO) && (r_vcnt == C_ZERO);
  assign w_ls     = w_run && (r_hcnt == C_ZERO);

  // Output stage: one-clock registered copy of the counter decode
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_hs   <= ~HS_ON;
      r_vs   <= ~VS_ON;
      r_de   <= 1'b0;
      r_x    <= C_ZERO;
      r_y    <= C_ZERO;
      r_fs   <= 1'b0;
      r_ls   <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_hs   <= w_hs_act ? HS_ON : ~HS_ON;
      r_vs   <= w_vs_act ? VS_ON : ~VS_ON;
      r_de   <= w_de;
      r_x    <= w_run ? r_hcnt : C_ZERO;
      r_y    <= w_run ? r_vcnt : C_ZERO;
      r_fs   <= w_fs;
      r_ls   <= w_ls;
      r_busy <= w_run;
    end
  end

  assign vid.oHS          = r_hs;
  assign vid.oVS          = r_vs;
  assign vid.oDE          = r_de;
  assign vid.oX           = r_x;
  assign vid.oY           = r_y;
  assign vid.oFRAME_START = r_fs;
  assign vid.oLINE_START  = r_ls;
  assign vid.oBUSY        = r_busy;

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Frames started since reset; steps on the same edge that raises oFRAME_START
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_frame_cnt <= 16'h0000;
    end else if (w_fs) begin
      r_frame_cnt <= r_frame_cnt + 16'h0001;
    end
  end

  assign vid.oFRAME_CNT = r_frame_cnt;
`else
  assign vid.oFRAME_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on an 8x6 raster (H 4/1/2/1, V 3/1/1/1, active-high syncs).
// Stimulus pushes hand-derived expected output vectors; a negedge monitor pops and compares them.
module tb_video_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic        ls;
    logic        busy;
    logic [11:0] x;
    logic [11:0] y;
    logic [15:0] fc;
  } exp_t;

  logic CLK;
  logic RST_N;

  video_timing_gen_if #(.CNT_WIDTH(12)) vid ();

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .CNT_WIDTH(12)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .vid  (vid)
  );

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cycle_n  = 0;
  int          fs_n     = 0;
  int          ls_n     = 0;
  int          de_n     = 0;
  int          fs_times[$];
  logic [15:0] exp_fc   = 16'h0000;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic exp_t get_act();
    exp_t a;
    a.hs   = vid.oHS;
    a.vs   = vid.oVS;
    a.de   = vid.oDE;
    a.fs   = vid.oFRAME_START;
    a.ls   = vid.oLINE_START;
    a.busy = vid.oBUSY;
    a.x    = vid.oX;
    a.y    = vid.oY;
    a.fc   = vid.oFRAME_CNT;
    return a;
  endfunction

  // Expected outputs while a given raster position is being shown
  function automatic exp_t mk_pix(input int x, input int y, input logic [15:0] fc);
    exp_t e;
    e.de   = (x < 4) && (y < 3);
    e.hs   = (x == 5) || (x == 6);
    e.vs   = (y == 4);
    e.fs   = (x == 0) && (y == 0);
    e.ls   = (x == 0);
    e.busy = 1'b1;
    e.x    = 12'(x);
    e.y    = 12'(y);
    e.fc   = fc;
    return e;
  endfunction

  function automatic exp_t mk_idle(input logic [15:0] fc);
    exp_t e;
    e      = '0;
    e.fc   = fc;
    return e;
  endfunction

  task automatic chk_vec(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t act hs=%b vs=%b de=%b fs=%b ls=%b busy=%b x=%0d y=%0d fc=%0d exp hs=%b vs=%b de=%b fs=%b ls=%b busy=%b x=%0d y=%0d fc=%0d",
               name, $time, act.hs, act.vs, act.de, act.fs, act.ls, act.busy, act.x, act.y, act.fc,
               exp.hs, exp.vs, exp.de, exp.fs, exp.ls, exp.busy, exp.x, exp.y, exp.fc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Monitor: tally strobes and compare the presented outputs against the scoreboard
  always @(negedge CLK) begin
    cycle_n++;
    if (vid.oFRAME_START === 1'b1) begin
      fs_n++;
      fs_times.push_back(cycle_n);
    end
    if (vid.oLINE_START === 1'b1) ls_n++;
    if (vid.oDE === 1'b1) de_n++;
    if (q.size() > 0) begin
      chk_vec("pixel", get_act(), q.pop_front());
    end
  end

  task automatic cyc(input logic en, input exp_t e);
    vid.iEN = en;
    @(posedge CLK);
    q.push_back(e);
    #1;
  endtask

  // mode 0: hold iEN, 1: stop at frame end, 2: drop at v=1 and raise at v=3, 3: drop at v=1 and stay low
  task automatic run_frame(input int mode);
    logic en;
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        case (mode)
          0:       en = 1'b1;
          1:       en = !((x == 7) && (y == 5));
          2:       en = !((y == 1) || (y == 2));
          default: en = (y == 0);
        endcase
`ifdef VIDEO_TIMING_FRAME_CNT_EN
        if ((x == 0) && (y == 0)) exp_fc = exp_fc + 16'h0001;
`endif
        cyc(en, mk_pix(x, y, exp_fc));
      end
    end
  endtask

  task automatic clear_tallies();
    fs_n = 0;
    ls_n = 0;
    de_n = 0;
    fs_times.delete();
  endtask

  initial begin
    RST_N   = 1'b1;
    vid.iEN = 1'b0;
    #1 RST_N = 1'b0;
    #21;
    chk_vec("reset_values", get_act(), mk_idle(16'h0000));
    RST_N = 1'b1;

    // Idle with iEN low after reset release
    for (int i = 0; i < 20; i++) cyc(1'b0, mk_idle(exp_fc));

    // Start and run three frames, stopping at the end of the third
    clear_tallies();
    cyc(1'b1, mk_idle(exp_fc));
    run_frame(0);
    run_frame(0);
    run_frame(1);
    for (int i = 0; i < 3; i++) cyc(1'b0, mk_idle(exp_fc));
    @(negedge CLK);
    #1;
    chk_int("frame_starts", fs_n, 3);
    chk_int("line_starts", ls_n, 18);
    chk_int("de_cycles", de_n, 36);
    if (fs_times.size() == 3) begin
      chk_int("frame_gap_1", fs_times[1] - fs_times[0], 48);
      chk_int("frame_gap_2", fs_times[2] - fs_times[1], 48);
    end else begin
      chk_int("frame_time_count", fs_times.size(), 3);
    end
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    chk_int("frame_cnt_3", int'(vid.oFRAME_CNT), 3);
`else
    chk_int("frame_cnt_off", int'(vid.oFRAME_CNT), 0);
`endif

    // Mid-frame iEN glitch has no effect, then a drop that lets the frame finish
    clear_tallies();
    cyc(1'b1, mk_idle(exp_fc));
    run_frame(2);
    run_frame(3);
    for (int i = 0; i < 3; i++) cyc(1'b0, mk_idle(exp_fc));
    @(negedge CLK);
    #1;
    chk_int("glitch_frames", fs_n, 2);

    // Asynchronous reset at (2,1), then restart from (0,0)
    cyc(1'b1, mk_idle(exp_fc));
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    exp_fc = exp_fc + 16'h0001;
`endif
    for (int x = 0; x < 8; x++) cyc(1'b1, mk_pix(x, 0, (x == 0) ? exp_fc : exp_fc));
    for (int x = 0; x < 3; x++) cyc(1'b1, mk_pix(x, 1, exp_fc));
    #5;
    RST_N = 1'b0;
    #1;
    chk_vec("async_reset", get_act(), mk_idle(16'h0000));
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    chk_vec("reset_hold", get_act(), mk_idle(16'h0000));
    RST_N  = 1'b1;
    exp_fc = 16'h0000;
    cyc(1'b1, mk_idle(exp_fc));
    run_frame(1);
    for (int i = 0; i < 2; i++) cyc(1'b0, mk_idle(exp_fc));
    @(negedge CLK);
    #1;
    chk_int("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator for the camera/display pixel pipeline. It runs horizontal and vertical counters from one pixel clock and drives HS/VS/DE plus pixel coordinates. It also emits a one-cycle frame-start strobe, which is the vsync-style update pulse consumed by the frame-latched register stage (`iVS` input). Start and stop are frame-aligned so that downstream consumers never see a partial frame.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line
- `H_FP`, 16: horizontal front porch, clocks
- `H_SYNC`, 96: horizontal sync width, clocks
- `H_BP`, 48: horizontal back porch, clocks
- `V_ACTIVE`, 480: active lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vertical sync width, lines
- `V_BP`, 33: vertical back porch, lines
- `HS_POL`, 0: 1 means HS is active-high; 0 means active-low
- `VS_POL`, 0: 1 means VS is active-high; 0 means active-low
- `CNT_WIDTH`, 12: counter and coordinate width. Must satisfy H_TOTAL and V_TOTAL ≤ 2^CNT_WIDTH.

Ports:
- `CLK`  in  1  pixel clock
- `RST_N`  in  1  reset. Asynchronous assert, active-low, one clock, asynchronous active-low reset.
- `iEN`  in  1  run request, level-sensitive
- `oHS`  out  1  horizontal sync, polarity set by HS_POL
- `oVS`  out  1  vertical sync, polarity set by VS_POL
- `oDE`  out  1  active-video enable
- `oX`  out  CNT_WIDTH  horizontal count
- `oY`  out  CNT_WIDTH  vertical count
- `oFRAME_START`  out  1  one-cycle pulse at pixel (0,0)
- `oLINE_START`  out  1  one-cycle pulse at h=0 of every line
- `oBUSY`  out  1  state is RUN
- `oFRAME_CNT`  out  16  frames started (see Configuration)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Segment order on each axis is active, front porch, sync, back porch.
- State machine:
  - IDLE: hcnt=vcnt=0. If iEN=1 is sampled, move to RUN.
  - RUN: hcnt increments every clock and wraps at H_TOTAL-1 to 0. vcnt increments on each h-wrap.
  - At (H_TOTAL-1, V_TOTAL-1): if iEN=1, wrap to (0,0) and stay in RUN. If iEN=0, go to IDLE.
- iEN falling mid-frame does not stop the generator; only iEN sampled at the last pixel decides. A deassert followed by a reassert before frame end has no effect.
- Decodes use counter values (h,v):
  - DE = (h<H_ACTIVE) & (v<V_ACTIVE)
  - HS active when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
  - VS active when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, and stays active for whole lines
  - FRAME_START = (h==0 & v==0)
  - LINE_START = (h==0)
- All decodes apply only in RUN. In IDLE, every strobe is inactive, syncs sit at their inactive level, and oX=oY=0.
- oX and oY are the registered counters; they are valid during blanking as well.

## Timing
- Every output is a registered copy of the decode of the previous cycle's counters and state, so there is a 1-clock latency from counters to outputs.
- Start: iEN=1 is sampled at edge N. The counter is at (0,0) after edge N. After edge N+1, oFRAME_START=1, oDE=1, oX=0, oY=0.
- Stop: the last frame's final pixel (H_TOTAL-1, V_TOTAL-1) appears on the outputs. One clock later all outputs are at idle values and oBUSY=0.
- Reset values:
  - oHS=~HS_POL, oVS=~VS_POL
  - oDE=0, oX=0, oY=0
  - oFRAME_START=0, oLINE_START=0, oBUSY=0
  - oFRAME_CNT=0
- Reset mid-frame returns to IDLE immediately. There is no partial-frame completion.
- Frame period is H_TOTAL×V_TOTAL clocks. Consecutive oFRAME_START pulses are exactly that far apart.

## Configuration
- `VIDEO_TIMING_FRAME_CNT_EN` defined:
  - oFRAME_CNT increments by 1 on the same cycle oFRAME_START is asserted.
  - It wraps from 0xFFFF to 0.
  - It is cleared only by reset; a stop does not clear it.
- Macro undefined: oFRAME_CNT is tied to 16'h0 and no counter register is built.

## Test plan
Test parameters: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), HS_POL=VS_POL=1, 48 clocks per frame.
- Reset release with iEN=0 held for 20 clocks -> all outputs stay at idle values, oBUSY=0.
- iEN=1 sampled at edge N -> oFRAME_START=1 after edge N+1, followed by exactly 3 lines of 4 DE cycles each. Within each line, oHS is high at h=5,6. oVS is high for all 8 clocks of v=4. The next oFRAME_START comes 48 clocks after the first.
- iEN held high for 3 frames -> exactly 3 oFRAME_START pulses, 18 oLINE_START pulses, and 36 DE cycles. With the macro defined, oFRAME_CNT=3.
- iEN dropped at v=1 and raised at v=3 -> frames continue with no gap. iEN dropped at v=1 and kept low -> the frame completes and oBUSY falls 1 clock after (7,5) is output.
- RST_N asserted at (2,1) -> outputs go to reset values asynchronously. After release with iEN=1, the frame restarts at (0,0) and oFRAME_CNT restarts from 0.
- Macro undefined, 3 frames run -> oFRAME_CNT stays 0 throughout.
